// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel FIFO.
//   lcd_sync_state_e : frame-resynchronisation state (used only when
//                      LCD_FIFO_SOF_SYNC_EN is defined)
//   SOF_BIT          : tuser bit carrying start-of-frame
package lcd_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF,
        RUN,
        FLUSH
    } lcd_sync_state_e;

    localparam int SOF_BIT = 0;

endpackage : lcd_pkg

// File: rtl/lcd_fifo_ram.sv
// Simple dual-port RAM backing the pixel FIFO, DATA_WIDTH x DEPTH.
//   clk          clock
//   we/waddr/wdata  write port
//   re/raddr     read port; rdata is registered and updates one cycle after re
module lcd_fifo_ram #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto block RAM; validity is
    // tracked by the pointers and the output select flag, not by contents.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: non-blocking for all clocked state so same-edge readers
            // see the pre-edge value.
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : lcd_fifo_ram

// File: rtl/lcd_pixel_fifo.sv
// Pixel FIFO between an AXI4-Stream video source and the LCD output stage.
//   aclk_i / rst_ni       clock, asynchronous active-low reset
//   s_axis_*              pixel input stream (tlast ignored, tuser[0] = SOF)
//   active_video_i        pop one pixel per cycle while high
//   lcd_dat_o             pixel out, one cycle after the pop; BLANK_COLOR otherwise
//   fill_o                occupancy 0..DEPTH
//   almost_full_o / almost_empty_o / prefill_ok_o  level flags from fill
//   underrun_o / clr_err_i  sticky underrun flag and its clear pulse
// Optional feature: define LCD_FIFO_SOF_SYNC_EN to flush after an underrun
// and wait for the next start-of-frame beat before accepting pixels again.
module lcd_pixel_fifo
    import lcd_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 18,
    parameter int                    DEPTH        = 256,
    parameter int                    USER_WIDTH   = 1,
    parameter int                    AFULL_LEVEL  = DEPTH - 4,
    parameter int                    AEMPTY_LEVEL = 4,
    parameter int                    START_LEVEL  = DEPTH / 2,
    parameter logic [DATA_WIDTH-1:0] BLANK_COLOR  = '0
) (
    input  logic                        aclk_i,
    input  logic                        rst_ni,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [USER_WIDTH-1:0]       s_axis_tuser,
    input  logic                        active_video_i,
    output logic [DATA_WIDTH-1:0]       lcd_dat_o,
    output logic [$clog2(DEPTH):0]      fill_o,
    output logic                        almost_full_o,
    output logic                        almost_empty_o,
    output logic                        prefill_ok_o,
    output logic                        underrun_o,
    input  logic                        clr_err_i
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    localparam logic [FILL_W-1:0] FULL_FILL  = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] AFULL_FILL = FILL_W'(AFULL_LEVEL);
    localparam logic [FILL_W-1:0] AEMPT_FILL = FILL_W'(AEMPTY_LEVEL);
    localparam logic [FILL_W-1:0] START_FILL = FILL_W'(START_LEVEL);

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [FILL_W-1:0]     fill_q;
    logic                  full, empty;
    logic                  wr, rd, underrun_evt;
    logic                  is_run, flush;
    logic                  rd_q;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // tlast is not stored; tuser is only consumed by the SOF sync option.
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tlast, s_axis_tuser};

    assign full  = (fill_q == FULL_FILL);
    assign empty = (fill_q == '0);

`ifdef LCD_FIFO_SOF_SYNC_EN
    lcd_sync_state_e state;
    logic            in_wait;

    assign is_run  = (state == RUN);
    assign in_wait = (state == WAIT_SOF);
    assign flush   = (state == FLUSH);

    // While waiting for SOF the source is drained; only the SOF beat is kept.
    assign s_axis_tready = in_wait || (is_run && !full);
    assign wr = s_axis_tvalid && s_axis_tready && (!in_wait || s_axis_tuser[SOF_BIT]);

    always_ff @(posedge aclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= WAIT_SOF;
        end else begin
            case (state)
                WAIT_SOF: if (s_axis_tvalid && s_axis_tuser[SOF_BIT]) state <= RUN;
                RUN:      if (underrun_evt) state <= FLUSH;
                FLUSH:    state <= WAIT_SOF;
                default:  state <= WAIT_SOF;
            endcase
        end
    end
`else
    assign is_run        = 1'b1;
    assign flush         = 1'b0;
    assign s_axis_tready = !full;
    assign wr            = s_axis_tvalid && s_axis_tready;
`endif

    // Pops and underruns only count in RUN; outside RUN the output is blank.
    assign rd           = active_video_i && !empty && is_run;
    assign underrun_evt = active_video_i &&  empty && is_run;

    always_ff @(posedge aclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // rd_q marks that ram_rdata holds a freshly popped pixel; resetting it
    // blanks the output immediately even though RAM data is not reset.
    always_ff @(posedge aclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q       <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            rd_q <= rd;
            if (underrun_evt)   underrun_o <= 1'b1;
            else if (clr_err_i) underrun_o <= 1'b0;
        end
    end

    lcd_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk   (aclk_i),
        .we    (wr),
        .waddr (wr_ptr),
        .wdata (s_axis_tdata),
        .re    (rd),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign lcd_dat_o      = rd_q ? ram_rdata : BLANK_COLOR;
    assign fill_o         = fill_q;
    assign almost_full_o  = (fill_q >= AFULL_FILL);
    assign almost_empty_o = (fill_q <= AEMPT_FILL);
    assign prefill_ok_o   = (fill_q >= START_FILL);

endmodule : lcd_pixel_fifo

// File: tb/tb_lcd_pixel_fifo.sv
// Directed testbench for lcd_pixel_fifo with DEPTH = 8 (AFULL 4, AEMPTY 4,
// START 4, BLANK 0). Inputs change and outputs are sampled 1 ns after the
// rising edge. Build with LCD_FIFO_SOF_SYNC_EN to include the resync steps.
module tb_lcd_pixel_fifo;

    localparam int DW    = 18;
    localparam int DEPTH = 8;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          aclk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [0:0]    s_axis_tuser = '0;
    logic          active_video_i = 1'b0;
    logic [DW-1:0] lcd_dat_o;
    logic [FW-1:0] fill_o;
    logic          almost_full_o, almost_empty_o, prefill_ok_o, underrun_o;
    logic          clr_err_i = 1'b0;

    int checks   = 0;
    int failures = 0;

    lcd_pixel_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .aclk_i         (aclk_i),
        .rst_ni         (rst_ni),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .active_video_i (active_video_i),
        .lcd_dat_o      (lcd_dat_o),
        .fill_o         (fill_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .prefill_ok_o   (prefill_ok_o),
        .underrun_o     (underrun_o),
        .clr_err_i      (clr_err_i)
    );

    always #5 aclk_i = ~aclk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk_i);
        #1;
    endtask

    initial begin
        // Reset
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        check("rst_fill",    32'(fill_o), 0);
        check("rst_dat",     32'(lcd_dat_o), 0);
        check("rst_underrun", 32'(underrun_o), 0);
        check("rst_aempty",  32'(almost_empty_o), 1);
        check("rst_prefill", 32'(prefill_ok_o), 0);

        // 1. Fill with 1..8; first beat flagged SOF
        for (int i = 1; i <= 8; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(i);
            s_axis_tuser  = (i == 1) ? 1'b1 : 1'b0;
            check("wr_ready", 32'(s_axis_tready), 1);
            step();
            if (i == 3) begin
                check("fill3_afull",  32'(almost_full_o), 0);
                check("fill3_aempty", 32'(almost_empty_o), 1);
                check("fill3_prefill", 32'(prefill_ok_o), 0);
            end
            if (i == 5) begin
                check("fill5_afull",  32'(almost_full_o), 1);
                check("fill5_aempty", 32'(almost_empty_o), 0);
                check("fill5_prefill", 32'(prefill_ok_o), 1);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        check("full_fill",  32'(fill_o), 8);
        check("full_ready", 32'(s_axis_tready), 0);
        check("full_afull", 32'(almost_full_o), 1);
        check("full_dat_blank", 32'(lcd_dat_o), 0);

        // 2. Drain 8 pixels
        active_video_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("drain_dat", 32'(lcd_dat_o), 32'(i));
        end
        active_video_i = 1'b0;
        check("drain_fill", 32'(fill_o), 0);
        check("drain_underrun", 32'(underrun_o), 0);
        step();
        check("idle_dat_blank", 32'(lcd_dat_o), 0);

        // 3. Steady write+read at fill 3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(10 + i);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            s_axis_tvalid  = 1'b1;
            s_axis_tdata   = DW'(13 + k);
            active_video_i = 1'b1;
            step();
            check("stream_dat",  32'(lcd_dat_o), 32'(10 + k));
            check("stream_fill", 32'(fill_o), 3);
        end
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("tail_dat", 32'(lcd_dat_o), 32'(30 + k));
        end
        check("tail_fill", 32'(fill_o), 0);

        // 4. Underrun: pop on empty
        step();
        check("ur_dat_blank", 32'(lcd_dat_o), 0);
        check("ur_set", 32'(underrun_o), 1);
`ifndef LCD_FIFO_SOF_SYNC_EN
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        check("ur_set_wins", 32'(underrun_o), 1);
`endif
        active_video_i = 1'b0;
        step();
        check("ur_sticky", 32'(underrun_o), 1);
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        check("ur_cleared", 32'(underrun_o), 0);

`ifdef LCD_FIFO_SOF_SYNC_EN
        // 5. Underrun in RUN -> FLUSH -> WAIT_SOF, resync on SOF beat
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 1'b1;
        s_axis_tdata  = DW'(18'h33);
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        check("sof_fill1", 32'(fill_o), 1);
        active_video_i = 1'b1;
        step();
        check("sof_pop", 32'(lcd_dat_o), 32'h33);
        step();
        check("flush_ready", 32'(s_axis_tready), 0);
        check("flush_underrun", 32'(underrun_o), 1);
        check("flush_dat_blank", 32'(lcd_dat_o), 0);
        active_video_i = 1'b0;
        step();
        check("wait_ready", 32'(s_axis_tready), 1);
        check("wait_fill", 32'(fill_o), 0);
        for (int i = 1; i <= 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(i);
            step();
            check("discard_fill", 32'(fill_o), 0);
        end
        s_axis_tuser = 1'b1;
        s_axis_tdata = DW'(18'hA5);
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        check("resync_fill", 32'(fill_o), 1);
        active_video_i = 1'b1;
        step();
        active_video_i = 1'b0;
        check("resync_first", 32'(lcd_dat_o), 32'hA5);
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
`endif

        // 6. Async reset mid-frame with fill 5
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(18'h100 + i);
            step();
        end
        s_axis_tdata   = DW'(18'h105);
        active_video_i = 1'b1;
        step();
        check("pre_rst_fill", 32'(fill_o), 5);
        check("pre_rst_dat", 32'(lcd_dat_o), 32'h100);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_fill", 32'(fill_o), 0);
        check("async_rst_dat",  32'(lcd_dat_o), 0);
        check("async_rst_underrun", 32'(underrun_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lcd_pixel_fifo
